// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, result and data_memory signals of the dmem arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
    output rdata,
    output mem_write, mem_read, mem_addr, mem_wdata
  );

  // Requesters plus data_memory side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
    input  rdata,
    input  mem_write, mem_read, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-requester arbiter in front of data_memory
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cap;
  logic              win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cap     = 1'b0;
    win     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          cap     = 1'b1;
          win     = (bus.m0_req && bus.m1_req) ? rr_q : bus.m1_req;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = bus.mem_rdata;
        end
        state_d = DONE;
      end
      DONE: begin
        // Only the requester that was not just served may chain a back-to-back access.
        rr_d = ~sel_q;
        win  = ~sel_q;
        if (win ? bus.m1_req : bus.m0_req) begin
          cap     = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cap) begin
      sel_d   = win;
      we_d    = win ? bus.m1_we    : bus.m0_we;
      addr_d  = win ? bus.m1_addr  : bus.m0_addr;
      wdata_d = win ? bus.m1_wdata : bus.m0_wdata;
    end
  end

  // Everything below decodes registered state, so req never reaches an output combinationally.
  assign bus.mem_write = (state_q == ACCESS) &&  we_q;
  assign bus.mem_read  = (state_q == ACCESS) && !we_q;
  assign bus.mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
  assign bus.mem_wdata = (state_q == ACCESS) ? wdata_q : '0;

  assign bus.m0_gnt    = (state_q == DONE) && !sel_q;
  assign bus.m1_gnt    = (state_q == DONE) &&  sel_q;
  assign bus.m0_rvalid = (state_q == DONE) && !sel_q && !we_q;
  assign bus.m1_rvalid = (state_q == DONE) &&  sel_q && !we_q;
  assign bus.rdata     = rdata_q;

endmodule
